// File: rtl/dca_lsu_rdata_unpacker.sv
// Assembles AXI R-channel beats of one row-sized load into a tensor row and writes it to the row buffer.
// Optional build macro DCA_LSU_RDATA_ERR_SQUASH_EN: rows that saw an error response are dropped instead of written.
module dca_lsu_rdata_unpacker #(
    parameter  int BW_AXI_DATA   = 32,
    parameter  int BW_TENSOR_ROW = 128,
    parameter  int BW_ROW_INDEX  = 6,
    localparam int ROW_BEATS     = BW_TENSOR_ROW / BW_AXI_DATA,
    localparam int BW_BEAT       = $clog2(ROW_BEATS) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       txn_valid,
    output logic                       txn_ready,
    input  logic [BW_ROW_INDEX-1:0]    txn_row_index,
    input  logic [BW_BEAT-1:0]         txn_num_beats,
    input  logic                       rvalid,
    output logic                       rready,
    input  logic [BW_AXI_DATA-1:0]     rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    output logic                       row_wvalid,
    input  logic                       row_wready,
    output logic [BW_TENSOR_ROW-1:0]   row_wdata,
    output logic [BW_TENSOR_ROW/8-1:0] row_wstrb,
    output logic [BW_ROW_INDEX-1:0]    row_windex,
    output logic                       busy,
    output logic                       err_resp,
    output logic                       err_last
);

    localparam int LANE_BYTES = BW_AXI_DATA / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BW_BEAT-1:0]   beat_cnt;
    logic [BW_BEAT-1:0]   nb;
    logic                 row_resp_err;
    logic                 txn_hs;
    logic                 r_hs;
    logic                 final_beat;
    logic                 beat_err;
    logic                 squash_row;

    // A zero or oversized beat count from the sequencer means "one full row".
    function automatic logic [BW_BEAT-1:0] sat_beats(input logic [BW_BEAT-1:0] n);
        if (n == '0 || n > BW_BEAT'(ROW_BEATS))
            return BW_BEAT'(ROW_BEATS);
        else
            return n;
    endfunction

    assign txn_hs     = txn_valid & txn_ready;
    assign r_hs       = rvalid & rready;
    assign final_beat = (beat_cnt == nb - BW_BEAT'(1));
    assign beat_err   = (rresp != 2'b00);
    assign busy       = (state != S_IDLE);

`ifdef DCA_LSU_RDATA_ERR_SQUASH_EN
    assign squash_row = row_resp_err | beat_err;
`else
    assign squash_row = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Handshake outputs depend on state only (plus enable/clear on the descriptor side),
    // so there is no path from rvalid to rready or from row_wready to row_wvalid.
    always_comb begin
        state_nxt  = state;
        txn_ready  = 1'b0;
        rready     = 1'b0;
        row_wvalid = 1'b0;
        case (state)
            S_IDLE: begin
                txn_ready = enable & ~clear & ~rst;
                if (txn_valid && txn_ready)
                    state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                rready = 1'b1;
                if (rvalid && final_beat)
                    state_nxt = squash_row ? S_IDLE : S_EMIT;
            end
            S_EMIT: begin
                row_wvalid = 1'b1;
                if (row_wready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (clear)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt     <= '0;
            nb           <= '0;
            row_resp_err <= 1'b0;
            err_resp     <= 1'b0;
            err_last     <= 1'b0;
            row_wdata    <= '0;
            row_wstrb    <= '0;
            row_windex   <= '0;
        end else if (clear) begin
            beat_cnt     <= '0;
            row_resp_err <= 1'b0;
            err_resp     <= 1'b0;
            err_last     <= 1'b0;
        end else if (txn_hs) begin
            row_windex   <= txn_row_index;
            nb           <= sat_beats(txn_num_beats);
            row_wstrb    <= '0;
            beat_cnt     <= '0;
            row_resp_err <= 1'b0;
        end else if (r_hs) begin
            // Lanes beyond the last beat keep their previous contents; only their strobes stay low.
            for (int i = 0; i < ROW_BEATS; i++) begin
                if (beat_cnt == BW_BEAT'(i)) begin
                    row_wdata[i*BW_AXI_DATA +: BW_AXI_DATA] <= rdata;
                    row_wstrb[i*LANE_BYTES +: LANE_BYTES]   <= '1;
                end
            end
            beat_cnt <= beat_cnt + BW_BEAT'(1);
            if (beat_err) begin
                row_resp_err <= 1'b1;
                err_resp     <= 1'b1;
            end
            // Beat count governs sequencing; rlast is only cross-checked.
            if (rlast != final_beat)
                err_last <= 1'b1;
        end
    end

endmodule
